// File: rtl/gpioemu_pkg.sv
// Shared types and register map for the gpioemu job sequencer.
// Holds the FSM state encoding, the sysbus register addresses and the counter sizing helper.
package gpioemu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        GAP,
        RD_S,
        S_WAIT,
        RD_W,
        W_WAIT,
        RESP
    } state_t;

    localparam logic [15:0] GPIO_ADDR_A   = 16'h0288;
    localparam logic [15:0] GPIO_ADDR_W   = 16'h0298;
    localparam logic [15:0] GPIO_ADDR_S   = 16'h02A0;
    localparam int          GPIO_BUSY_BIT = 0;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gpioemu_job_seq_if.sv
// Requester, response and gpioemu sysbus signals of the job sequencer.
// master = sequencer side, slave = requesters/consumer/peripheral side.
interface gpioemu_job_seq_if;

    logic        req0_valid;
    logic [31:0] req0_arg;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_arg;
    logic        req1_ready;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_timeout;

    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic        busy;

    modport master (
        input  req0_valid, req0_arg, req1_valid, req1_arg, rsp_ready, sdata_out,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
        output saddress, srd, swr, sdata_in, busy
    );

    modport slave (
        output req0_valid, req0_arg, req1_valid, req1_arg, rsp_ready, sdata_out,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
        input  saddress, srd, swr, sdata_in, busy
    );

endinterface

// File: rtl/gpioemu_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational (zero latency).
// A lone requester wins outright; on a tie the requester that did not win last time is granted.
module gpioemu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (enable) begin
            case (valid)
                2'b01: begin
                    grant  = 2'b01;
                    gnt_id = 1'b0;
                end
                2'b10: begin
                    grant  = 2'b10;
                    gnt_id = 1'b1;
                end
                2'b11: begin
                    gnt_id = ~rr_last;
                    grant  = rr_last ? 2'b01 : 2'b10;
                end
                default: begin
                    grant  = 2'b00;
                    gnt_id = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpioemu_job_seq.sv
// Sequences write-A / poll-S / read-W jobs on the gpioemu sysbus for two round-robin requesters.
// Unpolled latency accept->rsp_valid = 3+POLL_GAP+2*RD_LAT+... (14 default); response held until rsp_ready.
module gpioemu_job_seq
    import gpioemu_pkg::*;
#(
    parameter logic [15:0] ADDR_A    = GPIO_ADDR_A,
    parameter logic [15:0] ADDR_W    = GPIO_ADDR_W,
    parameter logic [15:0] ADDR_S    = GPIO_ADDR_S,
    parameter int          BUSY_BIT  = GPIO_BUSY_BIT,
    parameter int          RD_LAT    = 1,
    parameter int          POLL_GAP  = 8,
    parameter int          MAX_POLLS = 1024
) (
    input  logic               clk,
    input  logic               n_reset,
    gpioemu_job_seq_if.master  bus
);

    localparam int PW = cnt_width(MAX_POLLS);
    localparam int GW = cnt_width(POLL_GAP);
    localparam int LW = cnt_width(RD_LAT);

    state_t         state_q,       state_d;
    logic [GW-1:0]  gap_cnt_q,     gap_cnt_d;
    logic [LW-1:0]  lat_cnt_q,     lat_cnt_d;
    logic [PW-1:0]  poll_cnt_q,    poll_cnt_d;
    logic           rr_last_q,     rr_last_d;
    logic           rsp_valid_q,   rsp_valid_d;
    logic           rsp_id_q,      rsp_id_d;
    logic [31:0]    rsp_data_q,    rsp_data_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic [15:0]    saddress_q,    saddress_d;
    logic           srd_q,         srd_d;
    logic           swr_q,         swr_d;
    logic [31:0]    sdata_in_q,    sdata_in_d;
    logic           busy_q,        busy_d;

    logic [1:0]     grant;
    logic           gnt_id;

    // Readys stay low while reset is held so every output reads 0 in reset.
    gpioemu_rr_arb2 u_arb (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .rr_last (rr_last_q),
        .enable  ((state_q == IDLE) && !n_reset),
        .grant   (grant),
        .gnt_id  (gnt_id)
    );

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.saddress    = saddress_q;
    assign bus.srd         = srd_q;
    assign bus.swr         = swr_q;
    assign bus.sdata_in    = sdata_in_q;
    assign bus.busy        = busy_q;

    // Bus outputs are computed for the state being entered, so strobes line up with WR_A/RD_S/RD_W.
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        rr_last_d     = rr_last_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        saddress_d    = saddress_q;
        sdata_in_d    = sdata_in_q;
        srd_d         = 1'b0;
        swr_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d    = WR_A;
                    rr_last_d  = gnt_id;
                    rsp_id_d   = gnt_id;
                    saddress_d = ADDR_A;
                    sdata_in_d = gnt_id ? bus.req1_arg : bus.req0_arg;
                    swr_d      = 1'b1;
                end
            end
            WR_A: begin
                state_d    = GAP;
                gap_cnt_d  = GW'(POLL_GAP);
                poll_cnt_d = '0;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GW'(1)) begin
                    state_d    = RD_S;
                    saddress_d = ADDR_S;
                    srd_d      = 1'b1;
                end
            end
            RD_S: begin
                state_d    = S_WAIT;
                poll_cnt_d = poll_cnt_q + 1'b1;
                lat_cnt_d  = LW'(RD_LAT);
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == LW'(1)) begin
                    if (!bus.sdata_out[BUSY_BIT]) begin
                        state_d    = RD_W;
                        saddress_d = ADDR_W;
                        srd_d      = 1'b1;
                    end else if (poll_cnt_q == PW'(MAX_POLLS)) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(POLL_GAP);
                    end
                end
            end
            RD_W: begin
                state_d   = W_WAIT;
                lat_cnt_d = LW'(RD_LAT);
            end
            W_WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == LW'(1)) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = bus.sdata_out;
                    rsp_timeout_d = 1'b0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            poll_cnt_q    <= '0;
            rr_last_q     <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            saddress_q    <= '0;
            srd_q         <= 1'b0;
            swr_q         <= 1'b0;
            sdata_in_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            rr_last_q     <= rr_last_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            saddress_q    <= saddress_d;
            srd_q         <= srd_d;
            swr_q         <= swr_d;
            sdata_in_q    <= sdata_in_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_gpioemu_job_seq.sv
// Scoreboard bench for gpioemu_job_seq with a behavioural gpioemu register model on the sysbus.
// Expectations are queued at grant and retired at each response handshake.
module tb_gpioemu_job_seq;

    localparam logic [15:0] A_ADDR    = 16'h0288;
    localparam logic [15:0] W_ADDR    = 16'h0298;
    localparam logic [15:0] S_ADDR    = 16'h02A0;
    localparam int          MAXP      = 24;
    localparam int          LAT_NOPOLL = 14;

    typedef struct packed {
        logic        id;
        logic [31:0] arg;
        logic [31:0] data;
        logic        to;
        logic [15:0] polls;
        logic        wcnt;
    } exp_t;

    logic clk;
    logic n_reset;
    gpioemu_job_seq_if bus ();

    gpioemu_job_seq #(.MAX_POLLS(MAXP)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic grant_log[$];
    int   busy_cfg = 0;
    int   busy_left = 0;
    logic [31:0] a_reg = '0;

    int   cyc = 0;
    int   n_grants = 0;
    int   g_cyc = 0;
    int   last_rsp_cyc = 0;
    int   last_gap = 0;
    int   last_lat = 0;
    int   a_cnt = 0;
    int   s_cnt = 0;
    int   w_cnt = 0;
    logic [31:0] a_dat = '0;
    logic prev_strobe = 1'b0;
    logic prev_rv = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] func_w(input logic [31:0] x);
        return x * x + 32'h0001_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic on_grant(input logic id, input logic [31:0] arg);
        exp_t e;
        e.id  = id;
        e.arg = arg;
        if (busy_cfg >= MAXP) begin
            e.to = 1'b1; e.data = '0; e.polls = 16'(MAXP); e.wcnt = 1'b0;
        end else begin
            e.to = 1'b0; e.data = func_w(arg); e.polls = 16'(busy_cfg + 1); e.wcnt = 1'b1;
        end
        sb.push_back(e);
        grant_log.push_back(id);
        n_grants++;
        last_gap = cyc - last_rsp_cyc;
        g_cyc = cyc;
        a_cnt = 0; s_cnt = 0; w_cnt = 0;
    endtask

    // gpioemu register model: S reads busy for busy_cfg reads after each A write, data valid one cycle after srd.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.swr && bus.saddress == A_ADDR) begin
                a_reg     <= bus.sdata_in;
                busy_left <= busy_cfg;
            end
            if (bus.srd && bus.saddress == S_ADDR) begin
                bus.sdata_out <= 32'h0000_0100 | {31'h0, busy_left != 0};
                if (busy_left != 0) busy_left <= busy_left - 1;
            end else if (bus.srd && bus.saddress == W_ADDR) begin
                bus.sdata_out <= func_w(a_reg);
            end else begin
                bus.sdata_out <= 32'hDEAD_BEEF;
            end
        end
    end

    // Bus/handshake monitor sampled on the falling edge.
    initial begin
        exp_t e;
        logic strobe;
        forever begin
            @(negedge clk);
            cyc++;
            strobe = bus.swr | bus.srd;
            chk("strobe_rules", {62'h0, bus.swr & bus.srd, strobe & prev_strobe}, 64'h0);
            prev_strobe = strobe;
            if (bus.swr && bus.saddress == A_ADDR) begin a_cnt++; a_dat = bus.sdata_in; end
            if (bus.srd && bus.saddress == S_ADDR) s_cnt++;
            if (bus.srd && bus.saddress == W_ADDR) w_cnt++;
            if (bus.rsp_valid && !prev_rv) last_lat = cyc - g_cyc;
            prev_rv = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_timeout", bus.rsp_timeout, e.to);
                    chk("s_reads", s_cnt, e.polls);
                    chk("w_reads", w_cnt, e.wcnt);
                    chk("a_writes", a_cnt, 1);
                    chk("a_data", a_dat, e.arg);
                end
            end
            if (bus.req0_valid && bus.req0_ready) on_grant(1'b0, bus.req0_arg);
            if (bus.req1_valid && bus.req1_ready) on_grant(1'b1, bus.req1_arg);
        end
    end

    task automatic wait_grants(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && n_grants < target; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, n_grants, target);
    endtask

    task automatic wait_drain(input int bound, input string tag);
        for (int i = 0; i < bound && (sb.size() != 0 || bus.busy); i++) begin
            @(posedge clk); #1;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic run_job(input logic id, input logic [31:0] arg, input int bsy, input string tag);
        busy_cfg = bsy;
        if (id) begin bus.req1_arg = arg; bus.req1_valid = 1'b1; end
        else    begin bus.req0_arg = arg; bus.req0_valid = 1'b1; end
        wait_grants(n_grants + 1, 50, tag);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_drain(1000, tag);
    endtask

    initial begin
        int base;
        logic [3:0] ord;
        bus.req0_valid = 1'b0; bus.req0_arg = '0;
        bus.req1_valid = 1'b0; bus.req1_arg = '0;
        bus.rsp_ready  = 1'b1;
        n_reset = 1'b0;
        #2 n_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.busy, bus.srd, bus.swr, bus.rsp_valid, bus.rsp_timeout,
                        bus.rsp_id, bus.req0_ready, bus.req1_ready, bus.saddress}, 64'h0);
        chk("rst_sdata_in", bus.sdata_in, 64'h0);
        chk("rst_rsp_data", bus.rsp_data, 64'h0);
        @(posedge clk); #1 n_reset = 1'b0;

        // Single job with 20 busy polls.
        run_job(1'b0, 32'd4, 20, "t1_poll20");

        // No polling needed: fixed accept-to-response latency.
        run_job(1'b1, 32'd3, 0, "t1b_nopoll");
        chk("latency", last_lat, LAT_NOPOLL);

        // Simultaneous requests: 0 first, 1 granted the cycle after 0's response.
        busy_cfg = 2;
        base = n_grants;
        bus.req0_arg = 32'd4;  bus.req1_arg = 32'd20;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_grants(base + 1, 50, "t2_g0");
        bus.req0_valid = 1'b0;
        wait_grants(base + 2, 200, "t2_g1");
        bus.req1_valid = 1'b0;
        chk("t2_rdy_gap", last_gap, 1);
        wait_drain(300, "t2_drain");
        chk("t2_order", {grant_log[base], grant_log[base + 1]}, 2'b01);

        // Both continuously valid for four jobs.
        busy_cfg = 1;
        base = n_grants;
        bus.req0_arg = 32'd100; bus.req1_arg = 32'd200;
        bus.req0_valid = 1'b1;  bus.req1_valid = 1'b1;
        wait_grants(base + 4, 400, "t3_grants");
        bus.req0_valid = 1'b0;  bus.req1_valid = 1'b0;
        wait_drain(300, "t3_drain");
        ord = {grant_log[base], grant_log[base + 1], grant_log[base + 2], grant_log[base + 3]};
        chk("t3_order", ord, 4'b0101);

        // Stuck busy -> timeout after MAXP reads; one short of the limit still succeeds.
        run_job(1'b0, 32'd7, 1000, "t4_timeout");
        run_job(1'b1, 32'd6, MAXP - 1, "t4_lastpoll");

        // Consumer stalls for 30 cycles.
        bus.rsp_ready = 1'b0;
        busy_cfg = 0;
        bus.req1_arg = 32'd9; bus.req1_valid = 1'b1;
        wait_grants(n_grants + 1, 50, "t5_grant");
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_rsp_valid", bus.rsp_valid, 1);
        bus.req0_arg = 32'd1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t5_hold", {bus.rsp_valid, bus.rsp_id, bus.srd, bus.swr, bus.req0_ready,
                            bus.req1_ready, bus.rsp_data}, {6'b110000, func_w(32'd9)});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain(100, "t5_drain");

        // Reset pulse during GAP aborts the job; a following req1 job completes.
        busy_cfg = 0;
        bus.req0_arg = 32'd5; bus.req0_valid = 1'b1;
        wait_grants(n_grants + 1, 50, "t6_grant");
        bus.req0_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_busy_in_gap", bus.busy, 1);
        n_reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_ctl", {bus.busy, bus.srd, bus.swr, bus.rsp_valid, bus.rsp_timeout,
                           bus.rsp_id, bus.req0_ready, bus.req1_ready, bus.saddress}, 64'h0);
        chk("t6_rst_sdata_in", bus.sdata_in, 64'h0);
        chk("t6_rst_rsp_data", bus.rsp_data, 64'h0);
        sb.delete();
        @(posedge clk); #1 n_reset = 1'b0;
        run_job(1'b1, 32'd11, 0, "t6_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
